sprite_pixel_unit: RTL

- Per-scanline sprite pixel engine for the PPU background/sprite pipeline. Holds up to NUM_SPRITES sprites, each loaded during horizontal blank with X position, attributes and two pattern bytes.
- Counts each sprite down to its X position, then shifts out its 8 pixels. Resolves overlaps by slot priority.
- Delivers one 4-bit sprite pixel, a priority bit and a sprite-0 opaque flag per pixel to the pixel mux.

---
 rtl/sprite_pixel_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sprite_pixel_unit.sv
// -----------------------------------------------------------------------------
// sprite_pixel_unit
//
// Per-scanline sprite pixel engine. Up to NUM_SPRITES slots are loaded during
// horizontal blank with an X position, attributes and two pattern planes.
// Each pixel_en pulse first registers the resolved pixel for the current slot
// state, then moves every valid slot one pixel along the line: a slot counts
// its X position down to zero and then shifts its 8 pixels out MSB-first.
// Overlaps resolve to the lowest-index slot with an opaque pixel.
//
// Ports
//   clk             system clock
//   rst             synchronous, active-high reset
//   line_clear      invalidate every slot (start of sprite fetch)
//   load_en         write slot load_idx this cycle (ignored if out of range)
//   load_idx        slot to write
//   load_is_s0      loaded sprite is OAM sprite 0
//   load_attr       [3] hflip, [2] priority (1 = behind bg), [1:0] palette
//   load_x          sprite X coordinate
//   load_pat_lo     pattern plane 0
//   load_pat_hi     pattern plane 1
//   pixel_en        advance one visible pixel
//   sprite_pixel    {palette, hi, lo} of the winning slot; 0 = transparent
//   sprite_priority priority bit of the winning slot
//   sprite0_px      a sprite-0 slot is opaque at this pixel
//   active_mask     slots that were shifting pixels at this pixel
// -----------------------------------------------------------------------------
module sprite_pixel_unit #(
  parameter int NUM_SPRITES = 8,
  parameter int IDX_W       = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   line_clear,
  input  logic                   load_en,
  input  logic [IDX_W-1:0]       load_idx,
  input  logic                   load_is_s0,
  input  logic [3:0]             load_attr,
  input  logic [7:0]             load_x,
  input  logic [7:0]             load_pat_lo,
  input  logic [7:0]             load_pat_hi,
  input  logic                   pixel_en,
  output logic [3:0]             sprite_pixel,
  output logic                   sprite_priority,
  output logic                   sprite0_px,
  output logic [NUM_SPRITES-1:0] active_mask
);

  // Per-slot state.
  logic [NUM_SPRITES-1:0] valid;
  logic [NUM_SPRITES-1:0] is_s0;
  logic [3:0]             attr  [NUM_SPRITES];
  logic [7:0]             x_cnt [NUM_SPRITES];
  logic [3:0]             rem   [NUM_SPRITES];
  logic [7:0]             sh_lo [NUM_SPRITES];
  logic [7:0]             sh_hi [NUM_SPRITES];

  function automatic logic [7:0] bit_rev(input logic [7:0] v);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = v[7-b];
    return r;
  endfunction

  // Horizontal flip is applied once at load time so the shifters always
  // emit MSB-first.
  logic [7:0] pat_lo_in;
  logic [7:0] pat_hi_in;

  always_comb begin
    pat_lo_in = load_attr[3] ? bit_rev(load_pat_lo) : load_pat_lo;
    pat_hi_in = load_attr[3] ? bit_rev(load_pat_hi) : load_pat_hi;
  end

  // Resolution of the current slot state.
  logic [NUM_SPRITES-1:0] act;
  logic                   win_found;
  logic [3:0]             win_pix;
  logic                   win_pri;
  logic                   s0_hit;

  // NOTE: this is combinational, so it uses blocking assignments with every
  // variable given a default first; the loop relies on seeing win_found as
  // already updated by lower slots, which is what gives lowest-index priority.
  always_comb begin
    act       = '0;
    win_found = 1'b0;
    win_pix   = 4'd0;
    win_pri   = 1'b0;
    s0_hit    = 1'b0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      act[i] = valid[i] && (x_cnt[i] == 8'd0) && (rem[i] != 4'd0);
      // Only opaque pixels compete, so a transparent lower slot never
      // masks a higher one.
      if (act[i] && (sh_hi[i][7] || sh_lo[i][7])) begin
        if (!win_found) begin
          win_found = 1'b1;
          win_pix   = {attr[i][1:0], sh_hi[i][7], sh_lo[i][7]};
          win_pri   = attr[i][2];
        end
        if (is_s0[i]) s0_hit = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. The slot arrays
  // are small flop arrays rather than a RAM, so they are reset along with the
  // outputs to give a deterministic idle state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sprite_pixel    <= 4'd0;
      sprite_priority <= 1'b0;
      sprite0_px      <= 1'b0;
      active_mask     <= '0;
      valid           <= '0;
      is_s0           <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        attr[i]  <= 4'd0;
        x_cnt[i] <= 8'd0;
        rem[i]   <= 4'd0;
        sh_lo[i] <= 8'd0;
        sh_hi[i] <= 8'd0;
      end
    end else begin
      if (pixel_en) begin
        sprite_pixel    <= win_pix;
        sprite_priority <= win_pri;
        sprite0_px      <= s0_hit;
        active_mask     <= act;
      end
      for (int i = 0; i < NUM_SPRITES; i++) begin
        // A load beats both line_clear and advancing; an out-of-range
        // load_idx matches no slot and is dropped.
        if (load_en && (load_idx == IDX_W'(i))) begin
          valid[i] <= 1'b1;
          is_s0[i] <= load_is_s0;
          attr[i]  <= load_attr;
          x_cnt[i] <= load_x;
          rem[i]   <= 4'd8;
          sh_lo[i] <= pat_lo_in;
          sh_hi[i] <= pat_hi_in;
        end else if (line_clear) begin
          valid[i] <= 1'b0;
        end else if (pixel_en && valid[i]) begin
          if (x_cnt[i] != 8'd0) begin
            x_cnt[i] <= x_cnt[i] - 8'd1;
          end else if (rem[i] != 4'd0) begin
            sh_lo[i] <= {sh_lo[i][6:0], 1'b0};
            sh_hi[i] <= {sh_hi[i][6:0], 1'b0};
            rem[i]   <= rem[i] - 4'd1;
          end
        end
      end
    end
  end

endmodule
